rom_arbiter: RTL and testbench

ROM_ARBITER -- requirements
Module: rom_arbiter

---
 rtl/rom_arbiter.sv | 138 +++++++++++++
 tb/tb_rom_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_arbiter.sv
// Two-requester arbiter for a shared character ROM. Display has priority,
// with an anti-starvation override for the aux requester. Each issued read
// is tagged so that the returned byte is steered to the right requester.
`timescale 1ns/1ps
module rom_arbiter #(
    parameter int ROM_LAT    = 1,   // cycles from romEn to valid romData (1..4)
    parameter int STARVE_MAX = 8    // aux-losing cycles before aux is forced (1..15)
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       dispReq,
    input  logic [6:0] dispAddr,
    output logic       dispGnt,
    output logic       dispValid,
    output logic [7:0] dispData,
    input  logic       auxReq,
    input  logic [6:0] auxAddr,
    output logic       auxGnt,
    output logic       auxValid,
    output logic [7:0] auxData,
    output logic       romEn,
    output logic [6:0] romAddr,
    input  logic [7:0] romData
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DISP = 2'd1,
        ST_AUX  = 2'd2
    } state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t     state_reg, state_next;
    logic [3:0] starve_cnt_reg, starve_cnt_next;
    logic [6:0] rom_addr_reg, rom_addr_next;
    logic       aux_wins;

    // Next grant, captured address and starvation count from the sampled requests.
    always_comb begin
        state_next      = ST_IDLE;
        starve_cnt_next = starve_cnt_reg;
        rom_addr_next   = rom_addr_reg;
        aux_wins        = auxReq && (!dispReq || starve_cnt_reg == STARVE_LIM);
        if (aux_wins) begin
            state_next    = ST_AUX;
            rom_addr_next = auxAddr;
        end else if (dispReq) begin
            state_next    = ST_DISP;
            rom_addr_next = dispAddr;
        end
        // Count only cycles where aux is asking and display takes the ROM.
        if (!auxReq || aux_wins) begin
            starve_cnt_next = 4'd0;
        end else if (starve_cnt_reg != STARVE_LIM) begin
            starve_cnt_next = starve_cnt_reg + 4'd1;
        end
    end

    // Grant state, starvation counter and ROM address registers.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg      <= ST_IDLE;
            starve_cnt_reg <= 4'd0;
            rom_addr_reg   <= 7'd0;
        end else begin
            state_reg      <= state_next;
            starve_cnt_reg <= starve_cnt_next;
            rom_addr_reg   <= rom_addr_next;
        end
    end

    // The state register itself is the registered grant.
    assign dispGnt = (state_reg == ST_DISP);
    assign auxGnt  = (state_reg == ST_AUX);
    assign romEn   = dispGnt | auxGnt;
    assign romAddr = rom_addr_reg;

    // Tag pipeline: one stage per cycle of ROM latency, entered alongside romEn.
    logic [ROM_LAT-1:0] tag_valid_reg, tag_aux_reg;
    logic [ROM_LAT-1:0] tag_valid_in, tag_aux_in;

    genvar gi;
    generate
        for (gi = 0; gi < ROM_LAT; gi++) begin : g_tag
            if (gi == 0) begin : g_head
                assign tag_valid_in[gi] = romEn;
                assign tag_aux_in[gi]   = auxGnt;
            end else begin : g_body
                assign tag_valid_in[gi] = tag_valid_reg[gi-1];
                assign tag_aux_in[gi]   = tag_aux_reg[gi-1];
            end
        end
    endgenerate

    // Advance the tag pipeline; reset drops every read in flight.
    always_ff @(posedge clock) begin
        if (!reset) begin
            tag_valid_reg <= '0;
            tag_aux_reg   <= '0;
        end else begin
            tag_valid_reg <= tag_valid_in;
            tag_aux_reg   <= tag_aux_in;
        end
    end

    logic tag_done, tag_done_aux;
    assign tag_done     = tag_valid_reg[ROM_LAT-1];
    assign tag_done_aux = tag_aux_reg[ROM_LAT-1];

    logic       disp_valid_reg, aux_valid_reg;
    logic [7:0] disp_data_reg, aux_data_reg;

    // Steer the returning ROM byte to its owner; the other data register holds.
    always_ff @(posedge clock) begin
        if (!reset) begin
            disp_valid_reg <= 1'b0;
            aux_valid_reg  <= 1'b0;
            disp_data_reg  <= 8'd0;
            aux_data_reg   <= 8'd0;
        end else begin
            disp_valid_reg <= tag_done && !tag_done_aux;
            aux_valid_reg  <= tag_done && tag_done_aux;
            if (tag_done && !tag_done_aux) begin
                disp_data_reg <= romData;
            end
            if (tag_done && tag_done_aux) begin
                aux_data_reg <= romData;
            end
        end
    end

    assign dispValid = disp_valid_reg;
    assign auxValid  = aux_valid_reg;
    assign dispData  = disp_data_reg;
    assign auxData   = aux_data_reg;

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: two instances (ROM_LAT=1 and ROM_LAT=2) share the
// request inputs; each has its own ROM model. A cycle-indexed schedule of
// expected returns acts as the reference for grants, valids and data.
`timescale 1ns/1ps
module tb_rom_arbiter;

    localparam int         NCYC = 2048;
    localparam logic [3:0] SM4  = 4'd8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       dreq, areq;
    logic [6:0] daddr, aaddr;

    logic       d_gnt1, d_val1, a_gnt1, a_val1, en1;
    logic [7:0] d_dat1, a_dat1, rd1;
    logic [6:0] ra1;
    logic       d_gnt2, d_val2, a_gnt2, a_val2, en2;
    logic [7:0] d_dat2, a_dat2, rd2;
    logic [6:0] ra2;

    always #5 clk = ~clk;

    rom_arbiter #(.ROM_LAT(1), .STARVE_MAX(8)) dut1 (
        .clock(clk), .reset(rst_n),
        .dispReq(dreq), .dispAddr(daddr), .dispGnt(d_gnt1), .dispValid(d_val1), .dispData(d_dat1),
        .auxReq(areq), .auxAddr(aaddr), .auxGnt(a_gnt1), .auxValid(a_val1), .auxData(a_dat1),
        .romEn(en1), .romAddr(ra1), .romData(rd1)
    );

    rom_arbiter #(.ROM_LAT(2), .STARVE_MAX(8)) dut2 (
        .clock(clk), .reset(rst_n),
        .dispReq(dreq), .dispAddr(daddr), .dispGnt(d_gnt2), .dispValid(d_val2), .dispData(d_dat2),
        .auxReq(areq), .auxAddr(aaddr), .auxGnt(a_gnt2), .auxValid(a_val2), .auxData(a_dat2),
        .romEn(en2), .romAddr(ra2), .romData(rd2)
    );

    // ROM contents: a fixed scramble of the address.
    function automatic logic [7:0] rom_byte(input logic [6:0] a);
        logic [7:0] t;
        t = {1'b0, a} * 8'd29 + 8'd7;
        return t ^ 8'hA5;
    endfunction

    // ROM models with 1 and 2 cycles of read latency.
    logic [6:0] rp1, rp2a, rp2b;
    always @(posedge clk) begin
        rp1  <= ra1;
        rp2a <= ra2;
        rp2b <= rp2a;
    end
    assign rd1 = rom_byte(rp1);
    assign rd2 = rom_byte(rp2b);

    // Reference model state.
    int         cyc, total, bad;
    logic [3:0] m_cnt;
    logic       m_dgnt, m_agnt;
    logic [6:0] m_ra;
    logic       sv_v    [2][NCYC];
    logic       sv_aux  [2][NCYC];
    logic [6:0] sv_addr [2][NCYC];
    logic       m_dv [2];
    logic       m_av [2];
    logic [7:0] m_dd [2];
    logic [7:0] m_ad [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    // Predict the outputs after the coming edge, take the edge, compare.
    task automatic tick();
        logic aw, dw;
        if (!rst_n) begin
            m_cnt  = 4'd0;
            m_dgnt = 1'b0;
            m_agnt = 1'b0;
            m_ra   = 7'd0;
            for (int k = 0; k < 2; k++) begin
                m_dv[k] = 1'b0; m_av[k] = 1'b0; m_dd[k] = 8'd0; m_ad[k] = 8'd0;
                for (int i = cyc; i < NCYC; i++) sv_v[k][i] = 1'b0;
            end
        end else begin
            aw = areq && (!dreq || m_cnt == SM4);
            dw = dreq && !aw;
            if (!areq || aw) m_cnt = 4'd0;
            else if (m_cnt != SM4) m_cnt = m_cnt + 4'd1;
            m_dgnt = dw;
            m_agnt = aw;
            if (aw) m_ra = aaddr;
            else if (dw) m_ra = daddr;
            for (int k = 0; k < 2; k++) begin
                m_dv[k] = 1'b0;
                m_av[k] = 1'b0;
                if (sv_v[k][cyc]) begin
                    if (sv_aux[k][cyc]) begin
                        m_av[k] = 1'b1; m_ad[k] = rom_byte(sv_addr[k][cyc]);
                    end else begin
                        m_dv[k] = 1'b1; m_dd[k] = rom_byte(sv_addr[k][cyc]);
                    end
                end
                if (aw || dw) begin
                    sv_v[k][cyc+k+2]    = 1'b1;
                    sv_aux[k][cyc+k+2]  = aw;
                    sv_addr[k][cyc+k+2] = m_ra;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        if (m_dgnt || m_agnt)
            $display("txn cyc=%0d gnt=%s addr=%02h", cyc, m_dgnt ? "disp" : "aux", m_ra);
        check("issue_lat1", {22'd0, d_gnt1, a_gnt1, en1, ra1}, {22'd0, m_dgnt, m_agnt, m_dgnt | m_agnt, m_ra});
        check("issue_lat2", {22'd0, d_gnt2, a_gnt2, en2, ra2}, {22'd0, m_dgnt, m_agnt, m_dgnt | m_agnt, m_ra});
        check("return_lat1", {14'd0, d_val1, a_val1, d_dat1, a_dat1}, {14'd0, m_dv[0], m_av[0], m_dd[0], m_ad[0]});
        check("return_lat2", {14'd0, d_val2, a_val2, d_dat2, a_dat2}, {14'd0, m_dv[1], m_av[1], m_dd[1], m_ad[1]});
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            dreq = 1'b0; areq = 1'b0;
            tick();
        end
    endtask

    // Hold both requests for n cycles and tally the grant pattern.
    task automatic run_both(input int n, output int d_first, output int nd, output int na, output int nboth);
        int seen_aux;
        seen_aux = 0; d_first = 0; nd = 0; na = 0; nboth = 0;
        for (int i = 0; i < n; i++) begin
            dreq = 1'b1; areq = 1'b1;
            daddr = 7'($urandom); aaddr = 7'($urandom);
            tick();
            if (d_gnt1 && seen_aux == 0) d_first++;
            if (d_gnt1) nd++;
            if (a_gnt1) begin na++; seen_aux = 1; end
            if (d_gnt1 && a_gnt1) nboth++;
        end
    endtask

    typedef struct {
        logic       dreq;
        logic [6:0] daddr;
        logic       areq;
        logic [6:0] aaddr;
        logic       e_dg;
        logic       e_ag;
        logic [6:0] e_ra;
        logic       e_dv;
        logic       e_av;
    } vec_t;

    function automatic vec_t mk(input logic dr, input logic [6:0] da, input logic ar, input logic [6:0] aa,
                                input logic dg, input logic ag, input logic [6:0] ra,
                                input logic dv, input logic av);
        vec_t v;
        v.dreq = dr; v.daddr = da; v.areq = ar; v.aaddr = aa;
        v.e_dg = dg; v.e_ag = ag; v.e_ra = ra; v.e_dv = dv; v.e_av = av;
        return v;
    endfunction

    initial begin
        vec_t tbl [12];
        int   d_first, nd, na, nboth, cnt_a, cnt_d, cnt_v1, cnt_v2;

        total = 0; bad = 0; cyc = 0;
        m_cnt = 4'd0; m_dgnt = 1'b0; m_agnt = 1'b0; m_ra = 7'd0;
        for (int k = 0; k < 2; k++) begin
            m_dv[k] = 1'b0; m_av[k] = 1'b0; m_dd[k] = 8'd0; m_ad[k] = 8'd0;
            for (int i = 0; i < NCYC; i++) begin
                sv_v[k][i] = 1'b0; sv_aux[k][i] = 1'b0; sv_addr[k][i] = 7'd0;
            end
        end

        // Expected values are for the ROM_LAT=1 instance after each edge.
        tbl[0]  = mk(1, 7'h25, 0, 7'h00, 1, 0, 7'h25, 0, 0);
        tbl[1]  = mk(0, 7'h00, 0, 7'h00, 0, 0, 7'h25, 0, 0);
        tbl[2]  = mk(0, 7'h00, 0, 7'h00, 0, 0, 7'h25, 1, 0);
        tbl[3]  = mk(0, 7'h00, 1, 7'h11, 0, 1, 7'h11, 0, 0);
        tbl[4]  = mk(1, 7'h30, 1, 7'h12, 1, 0, 7'h30, 0, 0);
        tbl[5]  = mk(0, 7'h00, 1, 7'h12, 0, 1, 7'h12, 0, 1);
        tbl[6]  = mk(0, 7'h00, 0, 7'h00, 0, 0, 7'h12, 1, 0);
        tbl[7]  = mk(1, 7'h7F, 0, 7'h00, 1, 0, 7'h7F, 0, 1);
        tbl[8]  = mk(1, 7'h00, 0, 7'h00, 1, 0, 7'h00, 0, 0);
        tbl[9]  = mk(0, 7'h00, 0, 7'h00, 0, 0, 7'h00, 1, 0);
        tbl[10] = mk(0, 7'h00, 0, 7'h00, 0, 0, 7'h00, 1, 0);
        tbl[11] = mk(0, 7'h00, 0, 7'h00, 0, 0, 7'h00, 0, 0);

        // Reset: every output must read zero.
        rst_n = 1'b0; dreq = 1'b0; areq = 1'b0; daddr = 7'h55; aaddr = 7'h2A;
        tick();
        tick();
        rst_n = 1'b1;

        // Table vectors: single read, hold, aux-only, contention, back-to-back.
        for (int i = 0; i < 12; i++) begin
            dreq = tbl[i].dreq; daddr = tbl[i].daddr;
            areq = tbl[i].areq; aaddr = tbl[i].aaddr;
            tick();
            check($sformatf("table_row%0d", i), {22'd0, d_gnt1, a_gnt1, ra1, d_val1, a_val1},
                  {22'd0, tbl[i].e_dg, tbl[i].e_ag, tbl[i].e_ra, tbl[i].e_dv, tbl[i].e_av});
            if (i == 2) check("table_data_25", {24'd0, d_dat1}, {24'd0, rom_byte(7'h25)});
        end

        // Both held continuously: 8 display grants then 1 aux, repeating.
        run_both(27, d_first, nd, na, nboth);
        check("starve_first_run", d_first, 8);
        check("starve_disp_total", nd, 24);
        check("starve_aux_total", na, 3);
        check("starve_never_both", nboth, 0);
        idle(4);

        // Streaming: 16 consecutive display reads at 0x00..0x0F.
        cnt_d = 0; cnt_v1 = 0; cnt_v2 = 0;
        for (int i = 0; i < 16; i++) begin
            dreq = 1'b1; daddr = 7'(i); areq = 1'b0;
            tick();
            if (d_gnt1) cnt_d++;
            if (d_val1) cnt_v1++;
            if (d_val2) cnt_v2++;
        end
        for (int i = 0; i < 5; i++) begin
            dreq = 1'b0; areq = 1'b0;
            tick();
            if (d_val1) cnt_v1++;
            if (d_val2) cnt_v2++;
        end
        check("stream_grants", cnt_d, 16);
        check("stream_valids_lat1", cnt_v1, 16);
        check("stream_valids_lat2", cnt_v2, 16);

        // Withdraw: one-cycle aux pulse under display priority.
        cnt_a = 0; cnt_v1 = 0;
        dreq = 1'b1; areq = 1'b1; daddr = 7'h3C; aaddr = 7'h66;
        tick();
        if (a_gnt1) cnt_a++;
        for (int i = 0; i < 4; i++) begin
            dreq = 1'b1; areq = 1'b0;
            tick();
            if (a_gnt1) cnt_a++;
            if (a_val1 || a_val2) cnt_v1++;
        end
        check("withdraw_no_gnt", cnt_a, 0);
        check("withdraw_no_valid", cnt_v1, 0);
        run_both(9, d_first, nd, na, nboth);
        check("withdraw_cnt_cleared", d_first, 8);
        check("withdraw_then_aux", na, 1);
        idle(5);

        // Reset one cycle after three back-to-back grants; those reads vanish.
        for (int i = 0; i < 3; i++) begin
            dreq = 1'b1; daddr = 7'(8'h40 + i[7:0]); areq = 1'b0;
            tick();
        end
        cnt_v2 = 0;
        dreq = 1'b0; rst_n = 1'b0;
        tick();
        if (d_val2 || a_val2) cnt_v2++;
        check("reset_outputs_zero", {10'd0, d_gnt2, a_gnt2, en2, ra2, d_dat2, a_dat2, d_val2, a_val2},
              32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (d_val2 || a_val2) cnt_v2++;
        end
        check("reset_discards_reads", cnt_v2, 0);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            dreq  = ($urandom_range(0, 9) < 8);
            areq  = ($urandom_range(0, 9) < 6);
            daddr = 7'($urandom);
            aaddr = 7'($urandom);
            tick();
        end
        rst_n = 1'b1;
        idle(6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
